// File: rtl/i2c_pkg.sv
// Shared types and defaults for the i2c command sequencer and its command FIFO.
package i2c_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_RESP
    } seq_state_t;

    typedef struct packed {
        logic [2:0] addr;
        logic [7:0] data;
        logic       wr;
    } i2c_cmd_t;

    localparam int unsigned I2C_XFER_CYCLES = 24;

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Synchronous FIFO of i2c commands with full/empty flags and an occupancy count.
module i2c_cmd_fifo
    import i2c_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  i2c_cmd_t                     wdata,
    input  logic                         pop,
    output i2c_cmd_t                     rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    i2c_cmd_t        mem [DEPTH];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop_ok) begin
                rptr <= rptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/i2c_cmd_seq.sv
// Queues host transfer commands and launches them one at a time into the i2c engine,
// returning captured read bytes on a valid/ready response port.
module i2c_cmd_seq
    import i2c_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned XFER_CYCLES = I2C_XFER_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_addr,
    input  logic [7:0] cmd_data,
    input  logic       cmd_wr,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [2:0] rsp_addr,
    output logic [7:0] rsp_data,
    output logic       i2c_en,
    output logic [2:0] i2c_maddr,
    output logic [7:0] i2c_data,
    output logic       i2c_wr,
    input  logic [7:0] i2c_rdata,
    output logic       busy
);

    localparam int unsigned CNTW = $clog2(XFER_CYCLES);
    localparam int unsigned OCCW = $clog2(DEPTH + 1);

    seq_state_t       state;
    logic [CNTW-1:0]  cnt;
    i2c_cmd_t         hold;
    i2c_cmd_t         head;
    i2c_cmd_t         cmd_in;
    logic             full;
    logic             empty;
    logic             pop;
    logic [OCCW-1:0]  occupancy;

    assign cmd_in    = '{addr: cmd_addr, data: cmd_data, wr: cmd_wr};
    assign pop       = (state == ST_IDLE) && !empty;
    assign cmd_ready = !full;
    assign busy      = (state != ST_IDLE) || (occupancy != '0);
    assign i2c_maddr = hold.addr;
    assign i2c_data  = hold.data;
    assign i2c_wr    = hold.wr;

    i2c_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .wdata (cmd_in),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (occupancy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            hold      <= '0;
            i2c_en    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_addr  <= '0;
            rsp_data  <= '0;
        end else begin
            i2c_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        hold   <= head;
                        i2c_en <= 1'b1;
                        state  <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    cnt   <= CNTW'(XFER_CYCLES - 1);
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        if (!hold.wr) begin
                            rsp_data  <= i2c_rdata;
                            rsp_addr  <= hold.addr;
                            rsp_valid <= 1'b1;
                            state     <= ST_RESP;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cmd_seq.sv
// Directed bench for i2c_cmd_seq with hand-computed launch timing and response values.
module tb_i2c_cmd_seq;
    import i2c_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XFER  = 24;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       cmd_wr;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [2:0] rsp_addr;
    logic [7:0] rsp_data;
    logic       i2c_en;
    logic [2:0] i2c_maddr;
    logic [7:0] i2c_data;
    logic       i2c_wr;
    logic [7:0] i2c_rdata;
    logic       busy;

    int nvec = 0;
    int nmis = 0;

    logic [2:0] la_addr [8];
    logic [7:0] la_data [8];
    int         la_cyc  [8];
    int         la_n;
    int         acc_cyc;

    logic [2:0] wa [5] = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [7:0] wd [5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54};

    i2c_cmd_seq #(
        .DEPTH       (DEPTH),
        .XFER_CYCLES (XFER)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .cmd_wr    (cmd_wr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_addr  (rsp_addr),
        .rsp_data  (rsp_data),
        .i2c_en    (i2c_en),
        .i2c_maddr (i2c_maddr),
        .i2c_data  (i2c_data),
        .i2c_wr    (i2c_wr),
        .i2c_rdata (i2c_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] a, input logic [7:0] d, input logic w);
        cmd_addr  = a;
        cmd_data  = d;
        cmd_wr    = w;
        cmd_valid = 1'b1;
        check_eq("push_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && busy; i++) tick();
        check_eq("idle_reached", busy, 0);
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 300 && !rsp_valid; i++) tick();
        check_eq("rsp_reached", rsp_valid, 1);
    endtask

    // Runs until the block is idle, logging every launch and when a pending push is taken.
    task automatic collect();
        int   cyc = 0;
        logic acc;
        logic prev_en;
        bit   done = 0;
        prev_en = i2c_en;
        la_n    = 0;
        acc_cyc = -1;
        while (!done) begin
            acc = cmd_valid && cmd_ready;
            tick();
            cyc++;
            if (acc) begin
                cmd_valid = 1'b0;
                acc_cyc   = cyc;
            end
            if (i2c_en) begin
                check_eq("en_gap", prev_en, 0);
                if (la_n < 8) begin
                    la_addr[la_n] = i2c_maddr;
                    la_data[la_n] = i2c_data;
                    la_cyc[la_n]  = cyc;
                    la_n++;
                end
            end
            prev_en = i2c_en;
            if (!busy && !cmd_valid) begin
                done = 1;
            end else if (cyc >= 800) begin
                check_eq("collect_idle", busy, 0);
                done = 1;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_cmd_ready"}, cmd_ready, 1);
        check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
        check_eq({tag, "_rsp_addr"},  rsp_addr,  0);
        check_eq({tag, "_rsp_data"},  rsp_data,  0);
        check_eq({tag, "_i2c_en"},    i2c_en,    0);
        check_eq({tag, "_maddr"},     i2c_maddr, 0);
        check_eq({tag, "_data"},      i2c_data,  0);
        check_eq({tag, "_wr"},        i2c_wr,    0);
        check_eq({tag, "_busy"},      busy,      0);
        check_eq({tag, "_occ"},       dut.occupancy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int en_seen;
        int rv_seen;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_data  = '0;
        cmd_wr    = 1'b0;
        rsp_ready = 1'b0;
        i2c_rdata = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset then idle
        check_reset_outputs("rst");
        for (int i = 0; i < 50; i++) begin
            tick();
            check_eq("idle_ready", cmd_ready, 1);
            check_eq("idle_busy",  busy,      0);
            check_eq("idle_en",    i2c_en,    0);
        end

        // Single write: addr 5, data A5
        push(3'd5, 8'hA5, 1'b1);
        check_eq("wr_busy_queued", busy, 1);
        tick();
        check_eq("wr_en_launch", i2c_en, 1);
        check_eq("wr_maddr", i2c_maddr, 5);
        check_eq("wr_data",  i2c_data,  8'hA5);
        check_eq("wr_wr",    i2c_wr,    1);
        for (int k = 2; k <= int'(XFER) + 1; k++) begin
            tick();
            check_eq("wr_en_wait",   i2c_en,    0);
            check_eq("wr_maddr_hold", i2c_maddr, 5);
            check_eq("wr_data_hold", i2c_data,  8'hA5);
            check_eq("wr_wr_hold",   i2c_wr,    1);
            check_eq("wr_no_rsp",    rsp_valid, 0);
        end
        check_eq("wr_busy_in_wait", busy, 1);
        tick();
        check_eq("wr_done_busy", busy, 0);
        check_eq("wr_done_rsp",  rsp_valid, 0);

        // Single read: addr 2, engine returns 3C
        push(3'd2, 8'h00, 1'b0);
        tick();
        check_eq("rd_en_launch", i2c_en, 1);
        check_eq("rd_maddr", i2c_maddr, 2);
        check_eq("rd_wr",    i2c_wr,    0);
        i2c_rdata = 8'h3C;
        for (int k = 2; k <= int'(XFER) + 1; k++) begin
            tick();
            check_eq("rd_no_rsp_yet", rsp_valid, 0);
        end
        tick();
        check_eq("rd_rsp_valid", rsp_valid, 1);
        check_eq("rd_rsp_addr",  rsp_addr,  2);
        check_eq("rd_rsp_data",  rsp_data,  8'h3C);
        i2c_rdata = 8'h99;
        push(3'd7, 8'h11, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("rd_hold_no_en", i2c_en,    0);
            check_eq("rd_hold_valid", rsp_valid, 1);
            check_eq("rd_hold_data",  rsp_data,  8'h3C);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_eq("rd_accepted", rsp_valid, 0);
        check_eq("rd_accept_no_en", i2c_en, 0);
        tick();
        check_eq("post_rd_en",    i2c_en,    1);
        check_eq("post_rd_maddr", i2c_maddr, 7);
        check_eq("post_rd_data",  i2c_data,  8'h11);
        wait_idle();

        // Five pushes against DEPTH=4 while a read response is pending
        i2c_rdata = 8'h5A;
        push(3'd1, 8'h00, 1'b0);
        wait_rsp();
        check_eq("blk_rsp_addr", rsp_addr, 1);
        check_eq("blk_rsp_data", rsp_data, 8'h5A);
        for (int i = 0; i < 4; i++) begin
            push(wa[i], wd[i], 1'b1);
            check_eq("fill_ready", cmd_ready, (i < 3) ? 1 : 0);
        end
        cmd_addr  = wa[4];
        cmd_data  = wd[4];
        cmd_wr    = 1'b1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("full_ready", cmd_ready, 0);
            check_eq("full_occ",   dut.occupancy, 4);
            check_eq("full_no_en", i2c_en, 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_eq("full_rsp_clear", rsp_valid, 0);
        check_eq("full_still",     cmd_ready, 0);
        collect();
        check_eq("five_launches", la_n, 5);
        check_eq("first_launch_cyc", la_cyc[0], 1);
        check_eq("fifth_accept_cyc", acc_cyc, 2);
        for (int i = 0; i < 5 && i < la_n; i++) begin
            check_eq("order_addr", la_addr[i], wa[i]);
            check_eq("order_data", la_data[i], wd[i]);
            if (i > 0) check_eq("launch_spacing", la_cyc[i] - la_cyc[i-1], XFER + 2);
        end

        // Simultaneous push and pop at occupancy 2
        i2c_rdata = 8'h77;
        push(3'd6, 8'h00, 1'b0);
        wait_rsp();
        push(3'd1, 8'hC1, 1'b1);
        push(3'd2, 8'hC2, 1'b1);
        check_eq("pp_occ_before", dut.occupancy, 2);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_eq("pp_occ_idle", dut.occupancy, 2);
        cmd_addr  = 3'd3;
        cmd_data  = 8'hC3;
        cmd_wr    = 1'b1;
        cmd_valid = 1'b1;
        check_eq("pp_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check_eq("pp_occ_after", dut.occupancy, 2);
        check_eq("pp_en",    i2c_en,    1);
        check_eq("pp_maddr", i2c_maddr, 1);
        check_eq("pp_data",  i2c_data,  8'hC1);
        collect();
        check_eq("pp_launches", la_n, 2);
        check_eq("pp_addr1", la_addr[0], 2);
        check_eq("pp_data1", la_data[0], 8'hC2);
        check_eq("pp_addr2", la_addr[1], 3);
        check_eq("pp_data2", la_data[1], 8'hC3);

        // Reset midway through the WAIT of a read, with writes queued
        i2c_rdata = 8'hE7;
        push(3'd4, 8'h00, 1'b0);
        push(3'd5, 8'hD5, 1'b1);
        push(3'd6, 8'hD6, 1'b1);
        for (int i = 0; i < 12; i++) tick();
        check_eq("mid_busy", busy, 1);
        check_eq("mid_maddr", i2c_maddr, 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("mid_rst");
        en_seen = 0;
        rv_seen = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (i2c_en)    en_seen++;
            if (rsp_valid) rv_seen++;
        end
        check_eq("post_rst_en_count",  en_seen, 0);
        check_eq("post_rst_rsp_count", rv_seen, 0);
        check_eq("post_rst_busy",      busy,    0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/i2c_cmd_seq.md
# i2c_cmd_seq

Command sequencer that sits directly upstream of the `i2c` transaction engine. It buffers host-issued transfer commands (3-bit target address, 8-bit data, read/write flag) in a small FIFO. It launches each command into `i2c` with a single-cycle enable while holding the operands stable for a fixed transfer window. For reads, it captures the engine's `out` byte and returns it on a valid/ready response port.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `XFER_CYCLES`, 24: cycles the operands are held after launch; must cover the downstream idle→stop→idle sequence; ≥2.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cmd_valid`  in  1  host command present.
- `cmd_ready`  out  1  FIFO can accept; equals !full.
- `cmd_addr`  in  3  target address.
- `cmd_data`  in  8  write data (ignored for reads).
- `cmd_wr`  in  1  1 = write, 0 = read.
- `rsp_valid`  out  1  read data available.
- `rsp_ready`  in  1  host accepts response.
- `rsp_addr`  out  3  address of the completed read.
- `rsp_data`  out  8  read byte.
- `i2c_en`  out  1  launch pulse to engine `en`.
- `i2c_maddr`  out  3  to engine `maddr`.
- `i2c_data`  out  8  to engine `i2cdata`.
- `i2c_wr`  out  1  to engine `wr`.
- `i2c_rdata`  in  8  from engine `out`.
- `busy`  out  1  state≠IDLE or FIFO non-empty.

## Operation
- FIFO: push on `cmd_valid && cmd_ready`; pop only by the FSM in IDLE. Read/write pointers wrap modulo DEPTH; occupancy counter is $clog2(DEPTH+1) bits wide.
- Full: `cmd_ready`=0 even if a pop occurs that cycle. Empty: no pop.
- Push and pop in the same cycle on a non-full, non-empty FIFO: occupancy unchanged.
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE → LAUNCH when occupancy≠0. Pop the head into hold registers driving `i2c_maddr`/`i2c_data`/`i2c_wr`.
- LAUNCH: `i2c_en`=1 for exactly this one cycle. Load the wait counter with XFER_CYCLES-1, then go to WAIT.
- WAIT: hold registers stable and `i2c_en`=0. Decrement the counter each cycle. At 0: for a read, capture `i2c_rdata` into `rsp_data`, copy the hold address into `rsp_addr`, set `rsp_valid`, and go to RESP. For a write, go to IDLE.
- RESP: stay until `rsp_ready`=1 with `rsp_valid`=1, then clear `rsp_valid` and go to IDLE. No new launch occurs while a response is pending.
- Hold registers keep their last value in IDLE; `i2c_en` is never asserted for two consecutive cycles.
- Reset mid-operation: the in-flight command is dropped and no response is produced. The FIFO is emptied and the FSM returns to IDLE.

## Timing
- Reset values: `cmd_ready`=1, `rsp_valid`=0, `rsp_addr`=0, `rsp_data`=0, `i2c_en`=0, `i2c_maddr`=0, `i2c_data`=0, `i2c_wr`=0, `busy`=0, occupancy=0, FSM=IDLE.
- All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.
- Latency into an empty, idle block, with the command accepted at edge t:
  - FSM enters LAUNCH at edge t+1; `i2c_en` is high during cycle t+1.
  - WAIT spans edges t+2 … t+1+XFER_CYCLES.
  - A read has `rsp_valid`=1 after edge t+2+XFER_CYCLES. A write returns to IDLE at that edge.
- Back-to-back commands: next LAUNCH one cycle after returning to IDLE. Minimum period per write is XFER_CYCLES+2 cycles.
- `rsp_data` is sampled from `i2c_rdata` on the WAIT→RESP edge only.

## Structure
- Shared package `i2c_pkg`:
  - FSM state enum;
  - command struct {addr[2:0], data[7:0], wr} (12 bits);
  - default constant `I2C_XFER_CYCLES`=24.
- Sub-module `i2c_cmd_fifo`: parameterised synchronous FIFO of the command struct with full/empty/occupancy outputs. The sequencer FSM, wait counter and response register stay in `i2c_cmd_seq`.

## Test plan
- Reset then idle: `cmd_ready`=1, `busy`=0, `i2c_en`=0 for 50 cycles; all outputs 0.
- Single write, addr=3'd5, data=8'hA5, at edge t:
  - `i2c_en` high only in cycle t+1;
  - `i2c_maddr`=5, `i2c_data`=A5, `i2c_wr`=1 held through edge t+1+XFER_CYCLES;
  - `rsp_valid` stays 0.
- Single read, addr=3'd2, with `i2c_rdata` driven to 8'h3C during WAIT: `rsp_valid`=1, `rsp_addr`=2, `rsp_data`=3C after edge t+2+XFER_CYCLES. Hold `rsp_ready`=0 for 10 cycles; no further `i2c_en`. Next launch occurs after acceptance.
- Push 5 commands back-to-back with DEPTH=4:
  - `cmd_ready` drops after the 4th push while the first is still queued;
  - the 5th is accepted after the first pop;
  - launches occur in push order, spaced XFER_CYCLES+2 cycles apart.
- Simultaneous push and pop at occupancy 2: occupancy stays 2 and order is preserved.
- Assert `rst` for one cycle midway through WAIT of a read: all outputs return to reset values next cycle, no `rsp_valid` follows, and queued commands are discarded.
